// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Master is the MEM stage, slave is data_mem_responder.
interface data_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output req_size,
    output req_unsigned,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  req_size,
    input  req_unsigned,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory with lane steering and load extension.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LOCS   = 64,
  parameter int LATENCY    = 2
) (
  input logic clk,
  input logic rstn,
  data_mem_responder_if.slave bus
);

  localparam int IW = $clog2(NUM_LOCS);
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] NLOC = WW'(NUM_LOCS);
  localparam logic [3:0] CNT_INIT =
    4'(LATENCY > 0 ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            size_q;
  logic                  uns_q;

  logic [DATA_WIDTH-1:0] mem [NUM_LOCS];

  // While idle the request is used straight from the bus so a
  // zero-latency access can complete on its acceptance edge.
  logic                  write_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [1:0]            size_d;
  logic                  uns_d;

  logic                  go_resp;
  logic [WW-1:0]         word_idx;
  logic [IW-1:0]         mem_idx;
  logic                  range_err;
  logic                  size_err;
  logic                  mis_err;
  logic                  err;
  logic [1:0]            off;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] ld_val;
  logic [DATA_WIDTH-1:0] resp_d;
  logic                  we;

  // Select the live request or the captured one.
  always_comb begin
    if (state_q == S_IDLE) begin
      write_d = bus.req_write;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      size_d  = bus.req_size;
      uns_d   = bus.req_unsigned;
    end else begin
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
    end
  end

  assign word_idx  = addr_d[ADDR_WIDTH-1:2];
  assign mem_idx   = word_idx[IW-1:0];
  assign range_err = (word_idx >= NLOC);

  // Size decode: lane offset, byte enables, replicated write data.
  always_comb begin
    size_err = 1'b0;
    mis_err  = 1'b0;
    off      = addr_d[1:0];
    be       = 4'b0000;
    wd       = wdata_d;
    unique case (size_d)
      2'b00: begin
        be = 4'b0001 << off;
        wd = {4{wdata_d[7:0]}};
      end
      2'b01: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_err = addr_d[0];
`endif
        off = {addr_d[1], 1'b0};
        be  = 4'b0011 << off;
        wd  = {2{wdata_d[15:0]}};
      end
      2'b10: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_err = |addr_d[1:0];
`endif
        off = 2'b00;
        be  = 4'b1111;
      end
      default: size_err = 1'b1;
    endcase
  end

  assign err = range_err | size_err | mis_err;

  assign go_resp =
    ((state_q == S_IDLE) && bus.req_valid && (LATENCY == 0)) ||
    ((state_q == S_WAIT) && (cnt_q == 4'd0));

  assign we = go_resp && write_d && !err;

  assign rd_word = mem[mem_idx];
  assign sh      = rd_word >> {off, 3'b000};

  // Shift the selected lanes down and extend to full width.
  always_comb begin
    ld_val = sh;
    unique case (1'b1)
      size_d == 2'b00:
        ld_val = uns_d ? {24'd0, sh[7:0]}
                       : {{24{sh[7]}}, sh[7:0]};
      size_d == 2'b01:
        ld_val = uns_d ? {16'd0, sh[15:0]}
                       : {{16{sh[15]}}, sh[15:0]};
      default: ld_val = sh;
    endcase
  end

  assign resp_d = (write_d || err) ? '0 : ld_val;

  // Byte-lane store; rstn gating keeps a reset edge from committing.
  always_ff @(posedge clk) begin
    if (rstn && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[mem_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            write_q     <= bus.req_write;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            size_q      <= bus.req_size;
            uns_q       <= bus.req_unsigned;
            req_ready_q <= 1'b0;
            if (go_resp) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= err;
              rdata_q      <= resp_d;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (go_resp) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err;
            rdata_q      <= resp_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with LATENCY=2.
// Expected values are hand-computed little-endian results.
module tb_data_mem_responder;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  data_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  data_mem_responder #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_LOCS(64),
    .LATENCY(2)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request and complete its response handshake.
  task automatic do_req(
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [31:0] wdat,
    input  logic [1:0]  sz,
    input  logic        un,
    output logic [31:0] rd,
    output logic        er,
    output int          lat,
    output logic        ok
  );
    int n;
    ok  = 1'b0;
    rd  = '0;
    er  = 1'b0;
    lat = 0;
    @(negedge clk);
    bus.req_write    = wr;
    bus.req_addr     = a;
    bus.req_wdata    = wdat;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_valid    = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.resp_valid || n >= 40) break;
      @(posedge clk);
      lat++;
      n++;
    end
    if (!bus.resp_valid) return;
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
    end
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid);
    end
    checks++;
    if (bus.resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata);
    end
    checks++;
    if (bus.resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b exp=0", bus.resp_err);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic er, ok;
    int lat;
    do_req(1, 32'h0, 32'h11111111, 2'b10, 0, rd, er, lat, ok);
    do_req(1, 32'h20, 32'hCAFEF00D, 2'b10, 0, rd, er, lat, ok);
    do_req(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || er !== 0 || rd !== 0 || lat != 2) begin
      failures++;
      $display("FAIL sw_resp ok=%b err=%b rd=%h lat=%0d exp 1/0/0/2",
               ok, er, rd, lat);
    end
    do_req(0, 32'h10, 32'h0, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || er !== 0 || rd !== 32'hDEADBEEF || lat != 2) begin
      failures++;
      $display("FAIL lw_resp ok=%b err=%b rd=%h lat=%0d exp DEADBEEF lat 2",
               ok, er, rd, lat);
    end
  endtask

  task automatic test_extend();
    logic [31:0] a [4];
    logic [1:0]  s [4];
    logic        u [4];
    logic [31:0] e [4];
    logic [31:0] rd;
    logic er, ok;
    int lat;
    a[0] = 32'h13; s[0] = 2'b00; u[0] = 0; e[0] = 32'hFFFFFFDE;
    a[1] = 32'h11; s[1] = 2'b00; u[1] = 1; e[1] = 32'h000000BE;
    a[2] = 32'h12; s[2] = 2'b01; u[2] = 0; e[2] = 32'hFFFFDEAD;
    a[3] = 32'h10; s[3] = 2'b01; u[3] = 1; e[3] = 32'h0000BEEF;
    for (int i = 0; i < 4; i++) begin
      do_req(0, a[i], 32'h0, s[i], u[i], rd, er, lat, ok);
      checks++;
      if (ok !== 1 || er !== 0 || rd !== e[i]) begin
        failures++;
        $display("FAIL extend_%0d ok=%b err=%b got=%h exp=%h",
                 i, ok, er, rd, e[i]);
      end
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd;
    logic er, ok;
    int lat;
    do_req(1, 32'h12, 32'hAAAAAA55, 2'b00, 0, rd, er, lat, ok);
    do_req(0, 32'h10, 32'h0, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || rd !== 32'hDE55BEEF) begin
      failures++;
      $display("FAIL sb_lanes ok=%b got=%h exp=DE55BEEF", ok, rd);
    end
    do_req(1, 32'h8, 32'hA5A5A5A5, 2'b10, 0, rd, er, lat, ok);
    do_req(1, 32'hA, 32'hFFFF1234, 2'b01, 0, rd, er, lat, ok);
    do_req(0, 32'h8, 32'h0, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || rd !== 32'h1234A5A5) begin
      failures++;
      $display("FAIL sh_lanes ok=%b got=%h exp=1234A5A5", ok, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er, ok;
    int lat;
    do_req(0, 32'h100, 32'h0, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || er !== 1 || rd !== 0) begin
      failures++;
      $display("FAIL range_lw ok=%b err=%b rd=%h exp err=1 rd=0",
               ok, er, rd);
    end
    do_req(1, 32'h100, 32'hFFFFFFFF, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || er !== 1 || rd !== 0) begin
      failures++;
      $display("FAIL range_sw ok=%b err=%b rd=%h exp err=1 rd=0",
               ok, er, rd);
    end
    do_req(0, 32'h0, 32'h0, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || er !== 0 || rd !== 32'h11111111) begin
      failures++;
      $display("FAIL range_no_alias got=%h err=%b exp=11111111",
               rd, er);
    end
    do_req(1, 32'h10, 32'h0, 2'b11, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || er !== 1 || rd !== 0) begin
      failures++;
      $display("FAIL size11_sw ok=%b err=%b rd=%h exp err=1",
               ok, er, rd);
    end
    do_req(0, 32'h10, 32'h0, 2'b11, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || er !== 1 || rd !== 0) begin
      failures++;
      $display("FAIL size11_lw ok=%b err=%b rd=%h exp err=1 rd=0",
               ok, er, rd);
    end
    do_req(0, 32'h10, 32'h0, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || rd !== 32'hDE55BEEF) begin
      failures++;
      $display("FAIL size11_no_write got=%h exp=DE55BEEF", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic er, ok;
    int lat;
    int n;
    @(negedge clk);
    bus.req_write    = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_valid && n < 40);
    checks++;
    if (!bus.resp_valid) begin
      failures++;
      $display("FAIL hold_timeout resp_valid=%b exp=1", bus.resp_valid);
    end
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1 || bus.resp_rdata !== 32'hDE55BEEF ||
          bus.req_ready !== 0) begin
        failures++;
        $display("FAIL hold_%0d vld=%b rd=%h rdy=%b exp 1/DE55BEEF/0",
                 i, bus.resp_valid, bus.resp_rdata, bus.req_ready);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1 || bus.resp_valid !== 0) begin
      failures++;
      $display("FAIL release_idle rdy=%b vld=%b exp 1/0",
               bus.req_ready, bus.resp_valid);
    end
    do_req(0, 32'h0, 32'h0, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || rd !== 32'h11111111) begin
      failures++;
      $display("FAIL hold_no_accept got=%h exp=11111111", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er, ok;
    int lat;
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h12345678;
    bus.req_size  = 2'b10;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1 || bus.resp_valid !== 0) begin
      failures++;
      $display("FAIL midrst_idle rdy=%b vld=%b exp 1/0",
               bus.req_ready, bus.resp_valid);
    end
    do_req(0, 32'h20, 32'h0, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || rd !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL midrst_dropped got=%h exp=CAFEF00D", rd);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    logic er, ok;
    int lat;
    logic [31:0] e_rd;
    logic        e_er;
    do_req(0, 32'h22, 32'h0, 2'b10, 0, rd, er, lat, ok);
`ifdef DMEM_MISALIGN_TRAP_EN
    e_rd = 32'h0;
    e_er = 1'b1;
`else
    e_rd = 32'hCAFEF00D;
    e_er = 1'b0;
`endif
    checks++;
    if (ok !== 1 || er !== e_er || rd !== e_rd) begin
      failures++;
      $display("FAIL mis_lw err=%b rd=%h exp err=%b rd=%h",
               er, rd, e_er, e_rd);
    end
    do_req(0, 32'h11, 32'h0, 2'b01, 0, rd, er, lat, ok);
`ifdef DMEM_MISALIGN_TRAP_EN
    e_rd = 32'h0;
    e_er = 1'b1;
`else
    e_rd = 32'hFFFFBEEF;
    e_er = 1'b0;
`endif
    checks++;
    if (ok !== 1 || er !== e_er || rd !== e_rd) begin
      failures++;
      $display("FAIL mis_lh err=%b rd=%h exp err=%b rd=%h",
               er, rd, e_er, e_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er, ok;
    int lat;
    do_req(1, 32'h30, 32'h0BADF00D, 2'b10, 0, rd, er, lat, ok);
    do_req(0, 32'h30, 32'h0, 2'b10, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || rd !== 32'h0BADF00D || lat != 2) begin
      failures++;
      $display("FAIL b2b_lw got=%h lat=%0d exp=0BADF00D lat 2", rd, lat);
    end
    do_req(0, 32'h33, 32'h0, 2'b00, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || rd !== 32'h0000000B) begin
      failures++;
      $display("FAIL b2b_lb got=%h exp=0000000B", rd);
    end
    do_req(0, 32'h31, 32'h0, 2'b00, 0, rd, er, lat, ok);
    checks++;
    if (ok !== 1 || rd !== 32'hFFFFFFF0) begin
      failures++;
      $display("FAIL b2b_lb_neg got=%h exp=FFFFFFF0", rd);
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rstn             = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.resp_ready   = 1'b0;
    test_reset();
    test_store_load();
    test_extend();
    test_partial_store();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
